div_ctrl: RTL

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// Request arbiter and sequencer in front of an iterative divider: two
// round-robin requesters, zero-divisor and signed-overflow bypass, kill/abort.

package div;
    typedef enum logic {DIV = 1'b0, DIVU = 1'b1} op_t;
endpackage

module div_ctrl #(
    parameter int DIVLEN = 32,
    parameter int TAGW   = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  div::op_t          req0_op,
    input  logic [DIVLEN-1:0] req0_dividend,
    input  logic [DIVLEN-1:0] req0_divisor,
    input  logic [TAGW-1:0]   req0_tag,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  div::op_t          req1_op,
    input  logic [DIVLEN-1:0] req1_dividend,
    input  logic [DIVLEN-1:0] req1_divisor,
    input  logic [TAGW-1:0]   req1_tag,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DIVLEN-1:0] rsp_q,
    output logic [DIVLEN-1:0] rsp_r,
    output logic [TAGW-1:0]   rsp_tag,
    output logic              rsp_port,
    output logic              rsp_dz,

    input  logic              kill,

    output logic              div_start,
    output div::op_t          div_op,
    output logic [DIVLEN-1:0] div_dividend,
    output logic [DIVLEN-1:0] div_divisor,
    input  logic              div_done,
    input  logic [DIVLEN-1:0] div_q,
    input  logic [DIVLEN-1:0] div_r
);

    typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

    localparam logic [DIVLEN-1:0] MOST_NEG = {1'b1, {(DIVLEN-1){1'b0}}};

    state_t            r_state;
    logic              r_last;
    logic              r_div_start;
    logic              r_rsp_valid;
    logic [DIVLEN-1:0] r_rsp_q;
    logic [DIVLEN-1:0] r_rsp_r;
    logic [TAGW-1:0]   r_rsp_tag;
    logic              r_rsp_port;
    logic              r_rsp_dz;

    div::op_t          r_op;
    logic [DIVLEN-1:0] r_dividend;
    logic [DIVLEN-1:0] r_divisor;
    logic [TAGW-1:0]   r_tag;
    logic              r_port;

    logic              w_grant;
    logic              w_can_accept;
    logic              w_accept;
    div::op_t          w_op;
    logic [DIVLEN-1:0] w_dividend;
    logic [DIVLEN-1:0] w_divisor;
    logic [TAGW-1:0]   w_tag;
    logic              w_dz;
    logic              w_ovf;

    // A lone requester always wins; with both (or neither) valid the port
    // that was not served last gets the grant.
    always_comb begin
        w_grant = ~r_last;
        if (req0_valid && !req1_valid) begin
            w_grant = 1'b0;
        end else if (!req0_valid && req1_valid) begin
            w_grant = 1'b1;
        end
    end

    // NOTE: ready is gated combinationally by kill and reset so that a request
    // offered in a kill or reset cycle never completes its handshake.
    assign w_can_accept = (r_state == IDLE) && !kill && !reset;
    assign req0_ready   = w_can_accept && !w_grant;
    assign req1_ready   = w_can_accept &&  w_grant;
    assign w_accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign w_op       = w_grant ? req1_op       : req0_op;
    assign w_dividend = w_grant ? req1_dividend : req0_dividend;
    assign w_divisor  = w_grant ? req1_divisor  : req0_divisor;
    assign w_tag      = w_grant ? req1_tag      : req0_tag;

    assign w_dz  = (w_divisor == '0);
    assign w_ovf = (w_op == div::DIV) && (w_dividend == MOST_NEG) && (&w_divisor);

    // NOTE: the operand latches carry no reset; every use is preceded by a
    // handshake that loads them, so their power-up value is never observed.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_op       <= w_op;
            r_dividend <= w_dividend;
            r_divisor  <= w_divisor;
            r_tag      <= w_tag;
            r_port     <= w_grant;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_div_start <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_q     <= '0;
            r_rsp_r     <= '0;
            r_rsp_tag   <= '0;
            r_rsp_port  <= 1'b0;
            r_rsp_dz    <= 1'b0;
        end else if (kill) begin
            r_state     <= IDLE;
            r_div_start <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_last <= w_grant;
                        if (w_dz) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_q     <= '1;
                            r_rsp_r     <= w_dividend;
                            r_rsp_dz    <= 1'b1;
                            r_rsp_tag   <= w_tag;
                            r_rsp_port  <= w_grant;
                        end else if (w_ovf) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_q     <= w_dividend;
                            r_rsp_r     <= '0;
                            r_rsp_dz    <= 1'b0;
                            r_rsp_tag   <= w_tag;
                            r_rsp_port  <= w_grant;
                        end else begin
                            r_state     <= START;
                            r_div_start <= 1'b1;
                        end
                    end
                end
                // div_done is not looked at here: it may still be high from a
                // previous or abandoned operation.
                START: begin
                    r_div_start <= 1'b0;
                    r_state     <= BUSY;
                end
                BUSY: begin
                    if (div_done) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_q     <= div_q;
                        r_rsp_r     <= div_r;
                        r_rsp_dz    <= 1'b0;
                        r_rsp_tag   <= r_tag;
                        r_rsp_port  <= r_port;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_div_start <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_q        = r_rsp_q;
    assign rsp_r        = r_rsp_r;
    assign rsp_tag      = r_rsp_tag;
    assign rsp_port     = r_rsp_port;
    assign rsp_dz       = r_rsp_dz;

    assign div_start    = r_div_start;
    assign div_op       = r_op;
    assign div_dividend = r_dividend;
    assign div_divisor  = r_divisor;

endmodule
